// File: rtl/boxhead_key_debounce.sv
// Multi-key push-button debouncer: two-flop synchronizer per key, then a
// per-key STABLE/PENDING counter FSM producing a debounced level plus edge pulses.
module boxhead_key_debounce #(
   parameter int NUM_KEYS        = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter bit IN_ACTIVE_LOW   = 1'b1,
   parameter bit OUT_ACTIVE_LOW  = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] key_in,
   output logic [NUM_KEYS-1:0] key_out,
   output logic [NUM_KEYS-1:0] press_pulse,
   output logic [NUM_KEYS-1:0] release_pulse
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
   localparam logic [CW-1:0]       CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [NUM_KEYS-1:0] IN_POL   = {NUM_KEYS{IN_ACTIVE_LOW}};

   typedef enum logic {ST_STABLE, ST_PENDING} state_t;

   logic [NUM_KEYS-1:0] sync1_q, sync2_q;
   logic [NUM_KEYS-1:0] pressed_raw;

   // Synchronizers park at the released level so reset never looks like a press.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= IN_POL;
         sync2_q <= IN_POL;
      end else begin
         sync1_q <= key_in;
         sync2_q <= sync1_q;
      end
   end

   assign pressed_raw = sync2_q ^ IN_POL;

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      state_t        state_q;
      logic          s_q;
      logic [CW-1:0] cnt_q;
      logic          press_q, rel_q;
      logic          p;

      assign p = pressed_raw[k];

      always_ff @(posedge clk) begin
         if (reset) begin
            state_q <= ST_STABLE;
            s_q     <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
         end else begin
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            case (state_q)
               ST_STABLE: begin
                  if (p != s_q) begin
                     if (DEBOUNCE_CYCLES == 1) begin
                        s_q     <= p;
                        press_q <= p;
                        rel_q   <= ~p;
                     end else begin
                        state_q <= ST_PENDING;
                        cnt_q   <= CW'(1);
                     end
                  end
               end
               ST_PENDING: begin
                  if (p == s_q) begin
                     // Input bounced back before the window closed: discard.
                     state_q <= ST_STABLE;
                     cnt_q   <= '0;
                  end else if (cnt_q == CNT_LAST) begin
                     state_q <= ST_STABLE;
                     cnt_q   <= '0;
                     s_q     <= p;
                     press_q <= p;
                     rel_q   <= ~p;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               default: begin
                  state_q <= ST_STABLE;
                  cnt_q   <= '0;
               end
            endcase
         end
      end

      assign key_out[k]       = s_q ^ OUT_ACTIVE_LOW;
      assign press_pulse[k]   = press_q;
      assign release_pulse[k] = rel_q;
   end

endmodule

// File: tb/tb_boxhead_key_debounce.sv
// Directed bench: 4-key debouncer with a 4-cycle window, plus a 1-key
// instance with a 1-cycle window for the minimum-latency case.
module tb_boxhead_key_debounce;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] key_in;
   logic [3:0] key_out, press_pulse, release_pulse;
   logic [0:0] key_in1, key_out1, press1, release1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   boxhead_key_debounce #(.NUM_KEYS(4), .DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .key_in(key_in), .key_out(key_out),
      .press_pulse(press_pulse), .release_pulse(release_pulse));

   boxhead_key_debounce #(.NUM_KEYS(1), .DEBOUNCE_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .key_in(key_in1), .key_out(key_out1),
      .press_pulse(press1), .release_pulse(release1));

   // Packed observation words: {4'h0, key_out, press, release} and {13'h0, ko, pp, rp}
   function automatic logic [15:0] obs4();
      return {4'h0, key_out, press_pulse, release_pulse};
   endfunction

   function automatic logic [15:0] obs1();
      return {13'h0, key_out1, press1, release1};
   endfunction

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      reset   = 1'b1;
      key_in  = 4'hF;
      key_in1 = 1'b1;
      step(3);
      chk("reset_state4", obs4(), 16'h0F00);
      chk("reset_state1", obs1(), 16'h0004);
      reset = 1'b0;

      for (int i = 0; i < 20; i++) begin
         step(1);
         chk("idle", obs4(), 16'h0F00);
      end

      // Key 0 press: commit exactly on the 6th edge.
      key_in = 4'b1110;
      for (int i = 1; i <= 5; i++) begin
         step(1);
         chk("k0_press_wait", obs4(), 16'h0F00);
      end
      step(1);
      chk("k0_press_edge", obs4(), 16'h0E10);
      step(1);
      chk("k0_press_hold", obs4(), 16'h0E00);

      key_in = 4'hF;
      for (int i = 1; i <= 5; i++) begin
         step(1);
         chk("k0_rel_wait", obs4(), 16'h0E00);
      end
      step(1);
      chk("k0_rel_edge", obs4(), 16'h0F01);
      step(1);
      chk("k0_rel_hold", obs4(), 16'h0F00);

      // Key 1 bounce shorter than the window.
      key_in = 4'b1101;
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("k1_bounce_low", obs4(), 16'h0F00);
      end
      key_in = 4'hF;
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk("k1_bounce_after", obs4(), 16'h0F00);
      end

      // Simultaneous press of keys 1 and 3, then simultaneous release.
      key_in = 4'b0101;
      for (int i = 1; i <= 5; i++) begin
         step(1);
         chk("multi_press_wait", obs4(), 16'h0F00);
      end
      step(1);
      chk("multi_press_edge", obs4(), 16'h05A0);
      step(1);
      chk("multi_press_hold", obs4(), 16'h0500);
      key_in = 4'hF;
      step(5);
      chk("multi_rel_wait", obs4(), 16'h0500);
      step(1);
      chk("multi_rel_edge", obs4(), 16'h0F0A);
      step(1);
      chk("multi_rel_hold", obs4(), 16'h0F00);

      // Reset mid-pending on key 2 aborts the count.
      key_in = 4'b1011;
      step(3);
      chk("k2_pre_reset", obs4(), 16'h0F00);
      reset = 1'b1;
      step(1);
      chk("k2_in_reset_a", obs4(), 16'h0F00);
      step(1);
      chk("k2_in_reset_b", obs4(), 16'h0F00);
      reset = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         step(1);
         chk("k2_post_reset_wait", obs4(), 16'h0F00);
      end
      step(1);
      chk("k2_post_reset_edge", obs4(), 16'h0B40);
      step(1);
      chk("k2_post_reset_hold", obs4(), 16'h0B00);

      // One-cycle window: commit on the 3rd edge.
      key_in1 = 1'b0;
      step(2);
      chk("d1_press_wait", obs1(), 16'h0004);
      step(1);
      chk("d1_press_edge", obs1(), 16'h0002);
      step(1);
      chk("d1_press_hold", obs1(), 16'h0000);
      key_in1 = 1'b1;
      step(2);
      chk("d1_rel_wait", obs1(), 16'h0000);
      step(1);
      chk("d1_rel_edge", obs1(), 16'h0005);
      step(1);
      chk("d1_rel_hold", obs1(), 16'h0004);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/boxhead_key_debounce.md
BOXHEAD_KEY_DEBOUNCE -- requirements
Module: boxhead_key_debounce

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4: number of independent key channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000: stability time in clk cycles (10 ms at 50 MHz); legal range 1 to 2^24.
REQ-003 SHALL have parameter IN_ACTIVE_LOW, default 1: key_in reads 0 when a key is pressed.
REQ-004 SHALL have parameter OUT_ACTIVE_LOW, default 1: key_out reads 0 when a key is pressed, matching existing PIO software polarity.
REQ-005 SHALL have port clk, input, 1: single clock for all logic.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset sampled on the clk rising edge.
REQ-007 SHALL have port key_in, input, NUM_KEYS: raw asynchronous push-button levels from the board pins.
REQ-008 SHALL have port key_out, output, NUM_KEYS: debounced level per key, driven directly into the key PIO in_port.
REQ-009 SHALL have port press_pulse, output, NUM_KEYS: one-cycle high when a key's debounced state becomes pressed.
REQ-010 SHALL have port release_pulse, output, NUM_KEYS: one-cycle high when a key's debounced state becomes released.

Function
REQ-011 SHALL pass each key_in bit through a two-flop synchronizer; only the second flop output (sync) feeds debounce logic.
REQ-012 SHALL form per-key raw pressed level P = sync XOR IN_ACTIVE_LOW (1 = pressed).
REQ-013 SHALL keep per key a debounced state S (1 = pressed) and a counter C of width ceil(log2(DEBOUNCE_CYCLES+1)), minimum 1 bit.
REQ-014 SHALL run per key a two-state FSM: STABLE (P == S, C held at 0) and PENDING (P != S, C counting).
REQ-015 In STABLE, when P != S, SHALL go to PENDING with C <= 1 if DEBOUNCE_CYCLES > 1; if DEBOUNCE_CYCLES == 1, SHALL commit immediately per REQ-017.
REQ-016 In PENDING, when P == S, SHALL return to STABLE with C <= 0 and no change to S or pulses (glitch rejected).
REQ-017 In PENDING, when P != S and C == DEBOUNCE_CYCLES-1, SHALL set S <= P, C <= 0, return to STABLE, and in the same edge assert press_pulse (S 0->1) or release_pulse (S 1->0) for exactly one cycle.
REQ-018 In PENDING, when P != S and C < DEBOUNCE_CYCLES-1, SHALL increment C by 1; C SHALL never wrap or exceed DEBOUNCE_CYCLES-1.
REQ-019 SHALL drive key_out = S XOR OUT_ACTIVE_LOW from registered S; all outputs SHALL be registered.
REQ-020 Latency: a key_in level change held stable SHALL update key_out and fire the pulse exactly 2 + DEBOUNCE_CYCLES clk edges after the first edge that samples the new level.
REQ-021 A key_in change lasting fewer than DEBOUNCE_CYCLES + 0 edges at sync SHALL leave key_out and pulses unchanged.
REQ-022 Keys SHALL be fully independent; simultaneous transitions on several keys SHALL each produce their own pulse in the same cycle.
REQ-023 press_pulse and release_pulse for one key SHALL never be high in the same cycle.

Reset
REQ-024 While reset is high at a clk edge, synchronizer flops SHALL load the released level (IN_ACTIVE_LOW replicated), S <= 0, C <= 0, FSM <= STABLE.
REQ-025 Reset values: key_out = {NUM_KEYS{OUT_ACTIVE_LOW}} (4'b1111 default), press_pulse = 0, release_pulse = 0.
REQ-026 Reset asserted mid-PENDING SHALL abort the count with no pulse; after reset deasserts, a held press SHALL need a full 2 + DEBOUNCE_CYCLES edges.

Verification (DEBOUNCE_CYCLES = 4, defaults otherwise)
REQ-027 Reset then key_in = 4'b1111 idle -> key_out = 4'b1111, pulses 0 for 20 cycles.
REQ-028 key_in[0] 1->0 held -> key_out[0] = 0 and press_pulse = 4'b0001 for one cycle, exactly 6 edges after first sampling edge; later release -> release_pulse = 4'b0001 after 6 edges.
REQ-029 key_in[1] low for 3 cycles then high (bounce) -> key_out stays 4'b1111, no pulses.
REQ-030 key_in 4'b1111 -> 4'b0101 simultaneously -> press_pulse = 4'b1010 in one cycle, key_out = 4'b0101.
REQ-031 key_in[2] low, reset asserted after 3 edges, released, key_in[2] still low -> no pulse during or at reset; press_pulse[2] fires 6 edges after reset deassert.
REQ-032 Parameter DEBOUNCE_CYCLES = 1, NUM_KEYS = 1 -> press commits 3 edges after first sampling edge; counter never exceeds 0.
